// File: rtl/pe_mm_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_mm_seq_pkg
// Description : Shared definitions for the pe_mm_seq matrix-multiply sequencer:
//               FSM state encoding, state width and a clog2 helper used to
//               size the index and timeout counters.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_mm_seq_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_FEED  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Bits needed to hold values 0..value-1; never less than 1 so that a
  // counter of the returned width is always a legal vector.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_mm_idx_cnt.sv
`default_nettype none
// ============================================================================
// Module      : pe_mm_idx_cnt
// Description : Nested (i,j,k) index counter for the matrix sequencer.
//               j advances fastest across output elements, wrapping into i;
//               k walks the dot-product dimension and saturates at N-1.
// Ports       : clk, rst_n      - clock, async active-low reset
//               clr_all_i       - clear i, j and k
//               clr_k_i         - clear k only
//               inc_k_i         - advance k (holds at N-1)
//               adv_ij_i        - advance to next (i,j) in row-major order
//               i_o, j_o, k_o   - current indices
//               *_last_o        - index equals N-1
// Revision    : 1.0 - initial release
// ============================================================================
module pe_mm_idx_cnt #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_all_i,
  input  logic          clr_k_i,
  input  logic          inc_k_i,
  input  logic          adv_ij_i,
  output logic [IW-1:0] i_o,
  output logic [IW-1:0] j_o,
  output logic [IW-1:0] k_o,
  output logic          i_last_o,
  output logic          j_last_o,
  output logic          k_last_o
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [IW-1:0] i_q;
  logic [IW-1:0] j_q;
  logic [IW-1:0] k_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      if (clr_all_i) begin
        i_q <= '0;
        j_q <= '0;
      end else if (adv_ij_i) begin
        if (j_q != LAST_IDX) begin
          j_q <= j_q + 1'b1;
        end else begin
          j_q <= '0;
          if (i_q != LAST_IDX) i_q <= i_q + 1'b1;
        end
      end

      if (clr_all_i || clr_k_i) begin
        k_q <= '0;
      end else if (inc_k_i && (k_q != LAST_IDX)) begin
        k_q <= k_q + 1'b1;
      end
    end
  end

  assign i_o      = i_q;
  assign j_o      = j_q;
  assign k_o      = k_q;
  assign i_last_o = (i_q == LAST_IDX);
  assign j_last_o = (j_q == LAST_IDX);
  assign k_last_o = (k_q == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/pe_mm_seq.sv
`default_nettype none
// ============================================================================
// Module      : pe_mm_seq
// Description : Sequencer driving one FP multiply-accumulate PE to compute
//               C = A x B for NxN matrices in synchronous-read memories.
//               Per output element: clear PE, stream N operand pairs, wait
//               for the PE result (with timeout), write it to C.
// Ports       : clk, rst_n                - clock, async active-low reset
//               start / busy / done / err  - host handshake and status
//               a_* / b_*                  - A and B memory read ports
//               c_*                        - C memory write port
//               pe_start/valid/last/a/b    - PE operand interface
//               pe_c / pe_out_valid        - PE result interface
// Revision    : 1.0 - initial release
// ============================================================================
module pe_mm_seq
  import pe_mm_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  a_rd_en,
  output logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  b_rd_en,
  output logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  c_wr_en,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  pe_start,
  output logic                  pe_valid,
  output logic                  pe_last,
  output logic [DATA_WIDTH-1:0] pe_a,
  output logic [DATA_WIDTH-1:0] pe_b,
  input  logic [DATA_WIDTH-1:0] pe_c,
  input  logic                  pe_out_valid
);

  localparam int IW = clog2(N);
  localparam int TW = clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t                state_q;
  logic                  err_q;
  logic                  pe_valid_q;
  logic                  pe_last_q;
  logic [TW-1:0]         tmo_q;
  logic [DATA_WIDTH-1:0] c_wdata_q;

  logic [IW-1:0] i_idx;
  logic [IW-1:0] j_idx;
  logic [IW-1:0] k_idx;
  logic          i_last;
  logic          j_last;
  logic          k_last;
  logic          feed;
  logic          wr;

  // Row-major flattening, truncated to the memory address width.
  function automatic logic [ADDR_WIDTH-1:0] flat(input logic [IW-1:0] row,
                                                 input logic [IW-1:0] col);
    return ADDR_WIDTH'(int'(row) * N + int'(col));
  endfunction

  assign feed = (state_q == ST_FEED);
  assign wr   = (state_q == ST_WRITE);

  pe_mm_idx_cnt #(
    .N  (N),
    .IW (IW)
  ) u_idx (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_all_i ((state_q == ST_IDLE) && start),
    .clr_k_i   (state_q == ST_CLR),
    .inc_k_i   (feed),
    .adv_ij_i  ((state_q == ST_NEXT) && !(i_last && j_last)),
    .i_o       (i_idx),
    .j_o       (j_idx),
    .k_o       (k_idx),
    .i_last_o  (i_last),
    .j_last_o  (j_last),
    .k_last_o  (k_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      err_q      <= 1'b0;
      tmo_q      <= '0;
      c_wdata_q  <= '0;
      pe_valid_q <= 1'b0;
      pe_last_q  <= 1'b0;
    end else begin
      // One-cycle delay matches the synchronous memory read latency, so the
      // PE sees valid/last in the same cycle as the operand data.
      pe_valid_q <= feed;
      pe_last_q  <= feed && k_last;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            err_q   <= 1'b0;
            state_q <= ST_CLR;
          end
        end
        ST_CLR: begin
          tmo_q   <= '0;
          state_q <= ST_FEED;
        end
        ST_FEED: begin
          if (k_last) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (pe_out_valid) begin
            c_wdata_q <= pe_c;
            state_q   <= ST_WRITE;
          end else if (tmo_q == TMO_LAST) begin
            // Abandon the whole run; DONE lands exactly TIMEOUT cycles
            // after WAIT was entered.
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_WRITE: state_q <= ST_NEXT;
        ST_NEXT:  state_q <= (i_last && j_last) ? ST_DONE : ST_CLR;
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Control outputs decode only the state register, so they carry no
  // combinational path from inputs.
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign err      = err_q;
  assign a_rd_en  = feed;
  assign b_rd_en  = feed;
  assign a_addr   = feed ? flat(i_idx, k_idx) : '0;
  assign b_addr   = feed ? flat(k_idx, j_idx) : '0;
  assign c_wr_en  = wr;
  assign c_addr   = wr ? flat(i_idx, j_idx) : '0;
  assign c_wdata  = c_wdata_q;
  assign pe_start = (state_q == ST_CLR);
  assign pe_valid = pe_valid_q;
  assign pe_last  = pe_last_q;
  assign pe_a     = a_rdata;
  assign pe_b     = b_rdata;

endmodule
`default_nettype wire

// File: tb/tb_pe_mm_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_mm_seq
// Description : Self-checking bench for pe_mm_seq (N=2). Provides A/B
//               synchronous-read memories, a behavioural PE with fixed
//               latency, and a matrix-product reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_mm_seq;

  localparam int N   = 2;
  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int TMO = 20;
  localparam int LAT = 4;
  localparam int NE  = N * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, err;
  logic          a_rd_en, b_rd_en, c_wr_en;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic [DW-1:0] a_rdata = '0;
  logic [DW-1:0] b_rdata = '0;
  logic [DW-1:0] c_wdata, pe_a, pe_b, pe_c;
  logic          pe_start, pe_valid, pe_last, pe_out_valid;

  int n_checks = 0;
  int n_errors = 0;

  pe_mm_seq #(.DATA_WIDTH(DW), .N(N), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rdata(a_rdata),
    .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rdata(b_rdata),
    .c_wr_en(c_wr_en), .c_addr(c_addr), .c_wdata(c_wdata),
    .pe_start(pe_start), .pe_valid(pe_valid), .pe_last(pe_last),
    .pe_a(pe_a), .pe_b(pe_b), .pe_c(pe_c), .pe_out_valid(pe_out_valid)
  );

  always #5 clk = ~clk;

  // ---------------- FP32 helpers (exact for small integers) ----------------
  function automatic logic [31:0] int_to_fp32(input longint v);
    longint m;
    int p;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'((m << (23 - p)) & 64'h7F_FFFF);
    return r;
  endfunction

  function automatic longint fp32_to_int(input logic [31:0] f);
    int e;
    longint mag;
    e = int'(f[30:23]);
    if (e == 0) return 0;
    mag = {40'd0, 1'b1, f[22:0]} >> (150 - e);
    return f[31] ? -mag : mag;
  endfunction

  // ---------------- memories ----------------
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];

  always @(posedge clk) begin
    if (a_rd_en) a_rdata <= mem_a[a_addr];
    if (b_rd_en) b_rdata <= mem_b[b_addr];
  end

  // ---------------- behavioural PE ----------------
  bit          pe_never = 1'b0;
  bit          spur     = 1'b0;
  longint      acc_q    = 0;
  longint      hold_q   = 0;
  int          pend_q   = 0;
  logic        pe_ov_q  = 1'b0;
  logic [31:0] pe_c_q   = '0;
  longint      prod;

  assign prod = fp32_to_int(pe_a) * fp32_to_int(pe_b);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 0; hold_q <= 0; pend_q <= 0; pe_ov_q <= 1'b0; pe_c_q <= '0;
    end else begin
      pe_ov_q <= 1'b0;
      if (pe_start)      acc_q <= 0;
      else if (pe_valid) acc_q <= acc_q + prod;
      if (pe_valid && pe_last) begin
        hold_q <= acc_q + prod;
        pend_q <= LAT;
      end else if (pend_q > 0) begin
        pend_q <= pend_q - 1;
        if (pend_q == 1 && !pe_never) begin
          pe_ov_q <= 1'b1;
          pe_c_q  <= int_to_fp32(hold_q);
        end
      end
    end
  end

  // Spurious result injected only while operands are being fetched.
  assign pe_out_valid = pe_ov_q | (spur & a_rd_en);
  assign pe_c         = (spur & a_rd_en) ? 32'hDEAD_BEEF : pe_c_q;

  // ---------------- monitor (samples on falling edge) ----------------
  int            cyc = 0;
  int            done_total = 0;
  int            overlap_total = 0;
  int            done_cyc = 0;
  int            last_rd_cyc = 0;
  logic          err_at_done = 1'b0;
  logic [AW-1:0] wq_a[$];
  logic [DW-1:0] wq_d[$];
  logic          tr_st [4096];
  logic          tr_v  [4096];
  logic          tr_l  [4096];
  logic [AW-1:0] tr_aa [4096];
  logic [AW-1:0] tr_ba [4096];

  always @(negedge clk) begin
    tr_st[cyc & 4095] <= pe_start;
    tr_v [cyc & 4095] <= pe_valid;
    tr_l [cyc & 4095] <= pe_last;
    tr_aa[cyc & 4095] <= a_addr;
    tr_ba[cyc & 4095] <= b_addr;
    if (c_wr_en) begin
      wq_a.push_back(c_addr);
      wq_d.push_back(c_wdata);
    end
    if (done) begin
      done_total  <= done_total + 1;
      done_cyc    <= cyc;
      err_at_done <= err;
    end
    if (a_rd_en) last_rd_cyc <= cyc;
    if (pe_start && pe_valid) overlap_total <= overlap_total + 1;
    cyc <= cyc + 1;
  end

  // ---------------- stimulus data and reference ----------------
  logic [31:0] exp_d [NE];
  logic [31:0] dir_d [NE];
  int          trace_base;

  function automatic logic [9+3*AW+DW-1:0] outs_vec();
    return {busy, done, err, a_rd_en, b_rd_en, c_wr_en, pe_start, pe_valid,
            pe_last, a_addr, b_addr, c_addr, c_wdata};
  endfunction

  task automatic load_directed();
    mem_a[0] = 32'h3F80_0000; mem_a[1] = 32'h4000_0000;  // 1 2
    mem_a[2] = 32'h4040_0000; mem_a[3] = 32'h4080_0000;  // 3 4
    mem_b[0] = 32'h40A0_0000; mem_b[1] = 32'h40C0_0000;  // 5 6
    mem_b[2] = 32'h40E0_0000; mem_b[3] = 32'h4100_0000;  // 7 8
    dir_d[0] = 32'h4198_0000; dir_d[1] = 32'h41B0_0000;  // 19 22
    dir_d[2] = 32'h422C_0000; dir_d[3] = 32'h4248_0000;  // 43 50
  endtask

  // Start a job and follow it until done; entered and left at negedge+1.
  task automatic run_job(input bit spam, output int wbase, output int dcount,
                         output int blow);
    int  dbase;
    bit  seen;
    wbase      = wq_a.size();
    dbase      = done_total;
    blow       = 0;
    seen       = 1'b0;
    trace_base = cyc;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done_total != dbase) begin seen = 1'b1; break; end
      if (busy !== 1'b1) blow++;
      if (spam) start = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
    end
    start = 1'b0;
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL job_done_timeout: got no done within 400 cycles, want done");
    end
    repeat (3) begin @(negedge clk); #1; end
    dcount = done_total - dbase;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin @(negedge clk); #1; end
    n_checks++;
    if (outs_vec() !== '0) begin
      n_errors++; $display("FAIL reset_outputs: got %h want 0", outs_vec());
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (outs_vec() !== '0) begin
      n_errors++; $display("FAIL idle_outputs: got %h want 0", outs_vec());
    end
  endtask

  task automatic test_directed(input string nm, input bit spam);
    int wb, dc, bl;
    run_job(spam, wb, dc, bl);
    for (int e = 0; e < NE; e++) begin
      n_checks++;
      if (wq_a.size() <= wb + e) begin
        n_errors++;
        $display("FAIL %s_write%0d: got %0d writes want %0d", nm, e, wq_a.size() - wb, NE);
      end else if (wq_a[wb+e] !== AW'(e) || wq_d[wb+e] !== dir_d[e]) begin
        n_errors++;
        $display("FAIL %s_write%0d: got addr %0d data %h want addr %0d data %h",
                 nm, e, wq_a[wb+e], wq_d[wb+e], e, dir_d[e]);
      end
    end
    n_checks++;
    if (wq_a.size() != wb + NE) begin
      n_errors++; $display("FAIL %s_count: got %0d writes want %0d", nm, wq_a.size() - wb, NE);
    end
    n_checks++;
    if (dc != 1) begin n_errors++; $display("FAIL %s_done: got %0d pulses want 1", nm, dc); end
    n_checks++;
    if (bl != 0) begin n_errors++; $display("FAIL %s_busy: got %0d low cycles want 0", nm, bl); end
    n_checks++;
    if (err !== 1'b0) begin n_errors++; $display("FAIL %s_err: got %b want 0", nm, err); end
  endtask

  task automatic test_operand_seq();
    int t;
    logic ev, el;
    logic [AW-1:0] ea [2];
    logic [AW-1:0] eb [2];
    ea[0] = AW'(0); ea[1] = AW'(1);
    eb[0] = AW'(0); eb[1] = AW'(2);
    t = -1;
    for (int c = trace_base; c < trace_base + 40; c++)
      if (t < 0 && tr_st[c & 4095] === 1'b1) t = c;
    n_checks++;
    if (t < 0) begin
      n_errors++; $display("FAIL seq_pe_start: got no pe_start want one");
    end else begin
      for (int d = 1; d <= 4; d++) begin
        ev = (d == 2 || d == 3);
        el = (d == 3);
        n_checks++;
        if (tr_v[(t+d) & 4095] !== ev) begin
          n_errors++; $display("FAIL seq_valid_t+%0d: got %b want %b", d, tr_v[(t+d) & 4095], ev);
        end
        n_checks++;
        if (tr_l[(t+d) & 4095] !== el) begin
          n_errors++; $display("FAIL seq_last_t+%0d: got %b want %b", d, tr_l[(t+d) & 4095], el);
        end
      end
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (tr_aa[(t+1+k) & 4095] !== ea[k] || tr_ba[(t+1+k) & 4095] !== eb[k]) begin
          n_errors++;
          $display("FAIL seq_addr_k%0d: got a=%0d b=%0d want a=%0d b=%0d", k,
                   tr_aa[(t+1+k) & 4095], tr_ba[(t+1+k) & 4095], ea[k], eb[k]);
        end
      end
    end
    n_checks++;
    if (overlap_total != 0) begin
      n_errors++; $display("FAIL seq_overlap: got %0d start+valid cycles want 0", overlap_total);
    end
  endtask

  task automatic test_timeout();
    int wb, dc, bl;
    pe_never = 1'b1;
    run_job(1'b0, wb, dc, bl);
    pe_never = 1'b0;
    n_checks++;
    if (dc != 1) begin n_errors++; $display("FAIL tmo_done: got %0d pulses want 1", dc); end
    n_checks++;
    if (err_at_done !== 1'b1) begin
      n_errors++; $display("FAIL tmo_err_at_done: got %b want 1", err_at_done);
    end
    // WAIT begins the cycle after the last read; done follows TMO cycles later.
    n_checks++;
    if (done_cyc - last_rd_cyc != TMO + 1) begin
      n_errors++;
      $display("FAIL tmo_latency: got %0d want %0d", done_cyc - last_rd_cyc - 1, TMO);
    end
    n_checks++;
    if (wq_a.size() != wb) begin
      n_errors++; $display("FAIL tmo_nowrite: got %0d writes want 0", wq_a.size() - wb);
    end
    n_checks++;
    if (err !== 1'b1) begin n_errors++; $display("FAIL tmo_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_midrun();
    int  wb;
    bit  hit;
    wb  = wq_a.size();
    hit = 1'b0;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (wq_a.size() == wb + 2 && a_rd_en === 1'b1) begin hit = 1'b1; break; end
      @(negedge clk); #1;
    end
    n_checks++;
    if (!hit) begin n_errors++; $display("FAIL mid_reach_feed: got no FEED of (1,0) want it"); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs_vec() !== '0) begin
      n_errors++; $display("FAIL mid_async_outputs: got %h want 0", outs_vec());
    end
    repeat (2) begin @(negedge clk); #1; end
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (wq_a.size() != wb + 2) begin
      n_errors++; $display("FAIL mid_nowrite: got %0d writes want 2", wq_a.size() - wb);
    end
  endtask

  task automatic test_random(input int iters);
    int wb, dc, bl;
    longint ma [NE];
    longint mb [NE];
    longint s;
    for (int it = 0; it < iters; it++) begin
      for (int e = 0; e < NE; e++) begin
        ma[e] = longint'($urandom_range(0, 18)) - 9;
        mb[e] = longint'($urandom_range(0, 18)) - 9;
        mem_a[e] = int_to_fp32(ma[e]);
        mem_b[e] = int_to_fp32(mb[e]);
      end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          s = 0;
          for (int k = 0; k < N; k++) s += ma[i*N+k] * mb[k*N+j];
          exp_d[i*N+j] = int_to_fp32(s);
        end
      run_job(1'b0, wb, dc, bl);
      for (int e = 0; e < NE; e++) begin
        n_checks++;
        if (wq_a.size() <= wb + e) begin
          n_errors++;
          $display("FAIL rnd%0d_write%0d: got %0d writes want %0d", it, e, wq_a.size() - wb, NE);
        end else if (wq_a[wb+e] !== AW'(e) || wq_d[wb+e] !== exp_d[e]) begin
          n_errors++;
          $display("FAIL rnd%0d_write%0d: got addr %0d data %h want addr %0d data %h",
                   it, e, wq_a[wb+e], wq_d[wb+e], e, exp_d[e]);
        end
      end
      n_checks++;
      if (dc != 1 || wq_a.size() != wb + NE) begin
        n_errors++;
        $display("FAIL rnd%0d_shape: got %0d done %0d writes want 1 done %0d writes",
                 it, dc, wq_a.size() - wb, NE);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1);
  end

  initial begin
    load_directed();
    test_reset();
    test_directed("basic", 1'b0);
    test_operand_seq();
    test_directed("spam_start", 1'b1);
    test_directed("after_spam", 1'b0);
    test_timeout();
    test_directed("after_tmo", 1'b0);
    spur = 1'b1;
    test_directed("spurious", 1'b0);
    spur = 1'b0;
    test_reset_midrun();
    test_directed("after_reset", 1'b0);
    test_random(4);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
